button_conditioner: RTL and testbench

Front-end input stage between the raw board buttons and the game logic (player movement and shooting). Synchronizes the three asynchronous, bouncing push-button inputs into the 25 MHz domain and debounces them. Produces clean levels, a one-cycle shoot strobe per press, and left/right move strobes with auto-repeat while a direction is held. The player stage consumes these strobes, so one physical press yields exactly one shot and a controlled ship speed.

---
 rtl/game_pkg.sv | 25 ++
 rtl/button_debouncer.sv | 65 ++++++
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game front end: repeat-FSM state encoding
// and default button timing constants for the 25 MHz system clock.
package game_pkg;

    // Auto-repeat FSM state, kept as plain constants for legacy compatibility.
    typedef logic [1:0] rep_state_t;

    localparam rep_state_t ST_IDLE   = 2'd0;
    localparam rep_state_t ST_DELAY  = 2'd1;
    localparam rep_state_t ST_REPEAT = 2'd2;

    // Default timings at 25 MHz.
    localparam int unsigned DEBOUNCE_10MS      = 250000;
    localparam int unsigned REPEAT_DELAY_250MS = 6250000;
    localparam int unsigned REPEAT_PERIOD_50MS = 1250000;

    // Direction indices into the per-direction repeat arrays.
    localparam int unsigned DIR_LEFT  = 0;
    localparam int unsigned DIR_RIGHT = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
// level_o is the registered debounced level; level_nxt_o is the value
// level_o will take at the next clock edge, so the consumer can register
// strobes that line up with the level change.
module button_debouncer
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic level_nxt_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; flip the level on the last one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: debounces left/right/shoot, emits one shoot strobe per
// press and left/right move strobes with auto-repeat while held.
module button_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_250MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_50MS
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_left,
    input  logic i_right,
    input  logic i_shoot,
    output logic o_left_level,
    output logic o_right_level,
    output logic o_shoot_level,
    output logic o_left_pulse,
    output logic o_right_pulse,
    output logic o_shoot_pulse
);

    localparam int unsigned     RCW         = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RCW-1:0]  DELAY_LOAD  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0]  PERIOD_LOAD = RCW'(REPEAT_PERIOD - 1);

    logic [1:0]     dir_lvl;
    logic [1:0]     dir_lvl_nxt;
    logic           shoot_lvl;
    logic           shoot_lvl_nxt;

    rep_state_t     state_q [2];
    rep_state_t     state_d [2];
    logic [RCW-1:0] cnt_q   [2];
    logic [RCW-1:0] cnt_d   [2];
    logic [1:0]     strobe;
    logic           both_held;

    logic           left_pulse_q;
    logic           left_pulse_d;
    logic           right_pulse_q;
    logic           right_pulse_d;
    logic           shoot_pulse_q;
    logic           shoot_pulse_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk_i       (i_clk_25MHz),
        .rst_i       (i_reset),
        .btn_i       (i_left),
        .level_o     (dir_lvl[DIR_LEFT]),
        .level_nxt_o (dir_lvl_nxt[DIR_LEFT])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk_i       (i_clk_25MHz),
        .rst_i       (i_reset),
        .btn_i       (i_right),
        .level_o     (dir_lvl[DIR_RIGHT]),
        .level_nxt_o (dir_lvl_nxt[DIR_RIGHT])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_shoot (
        .clk_i       (i_clk_25MHz),
        .rst_i       (i_reset),
        .btn_i       (i_shoot),
        .level_o     (shoot_lvl),
        .level_nxt_o (shoot_lvl_nxt)
    );

    // Repeat FSMs run on the next-cycle level so strobes register together
    // with the debounced level change they belong to.
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            strobe[d]  = 1'b0;
            case (state_q[d])
                ST_IDLE: begin
                    if (dir_lvl_nxt[d] && !dir_lvl[d]) begin
                        state_d[d] = ST_DELAY;
                        cnt_d[d]   = DELAY_LOAD;
                        strobe[d]  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!dir_lvl_nxt[d]) begin
                        state_d[d] = ST_IDLE;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == '0) begin
                        state_d[d] = ST_REPEAT;
                        cnt_d[d]   = PERIOD_LOAD;
                        strobe[d]  = 1'b1;
                    end else begin
                        cnt_d[d] = cnt_q[d] - 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!dir_lvl_nxt[d]) begin
                        state_d[d] = ST_IDLE;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == '0) begin
                        cnt_d[d]  = PERIOD_LOAD;
                        strobe[d] = 1'b1;
                    end else begin
                        cnt_d[d] = cnt_q[d] - 1'b1;
                    end
                end
                default: begin
                    state_d[d] = ST_IDLE;
                    cnt_d[d]   = '0;
                end
            endcase
        end
    end

    // Repeat FSM state and counters.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            for (int unsigned d = 0; d < 2; d++) begin
                state_q[d] <= ST_IDLE;
                cnt_q[d]   <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
        end
    end

    // Opposing directions cancel; the FSMs keep their phase underneath.
    always_comb begin
        both_held     = &dir_lvl_nxt;
        left_pulse_d  = strobe[DIR_LEFT]  & ~both_held;
        right_pulse_d = strobe[DIR_RIGHT] & ~both_held;
        shoot_pulse_d = shoot_lvl_nxt & ~shoot_lvl;
    end

    // Registered strobe outputs.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            left_pulse_q  <= 1'b0;
            right_pulse_q <= 1'b0;
            shoot_pulse_q <= 1'b0;
        end else begin
            left_pulse_q  <= left_pulse_d;
            right_pulse_q <= right_pulse_d;
            shoot_pulse_q <= shoot_pulse_d;
        end
    end

    assign o_left_level  = dir_lvl[DIR_LEFT];
    assign o_right_level = dir_lvl[DIR_RIGHT];
    assign o_shoot_level = shoot_lvl;
    assign o_left_pulse  = left_pulse_q;
    assign o_right_pulse = right_pulse_q;
    assign o_shoot_pulse = shoot_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timings
// (debounce 4, repeat delay 10, repeat period 5).
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic left;
    logic right;
    logic shoot;
    logic left_level, right_level, shoot_level;
    logic left_pulse, right_pulse, shoot_pulse;
    logic [5:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .i_clk_25MHz   (clk),
        .i_reset       (reset),
        .i_left        (left),
        .i_right       (right),
        .i_shoot       (shoot),
        .o_left_level  (left_level),
        .o_right_level (right_level),
        .o_shoot_level (shoot_level),
        .o_left_pulse  (left_pulse),
        .o_right_pulse (right_pulse),
        .o_shoot_pulse (shoot_pulse)
    );

    // Output vector order: {left_level, right_level, shoot_level, left_pulse, right_pulse, shoot_pulse}
    assign outs = {left_level, right_level, shoot_level, left_pulse, right_pulse, shoot_pulse};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic chk(input string tag, input int c, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            chk(tag, c, outs, 6'b000000);
        end
    endtask

    initial begin
        reset = 1'b1;
        left  = 1'b0;
        right = 1'b0;
        shoot = 1'b0;

        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk("reset", c, outs, 6'b000000);
        end
        reset = 1'b0;
        quiet("idle");

        // Shoot held 20 cycles: level 6..25, single pulse at 6, none on release.
        for (int c = 1; c <= 30; c++) begin
            shoot = (c <= 20);
            cyc();
            chk("shoot", c, outs, {1'b0, 1'b0, rng(c, 6, 25), 1'b0, 1'b0, (c == 6)});
        end
        quiet("gap1");

        // Bounce: 3-cycle highs/lows never reach the 4-cycle threshold.
        for (int c = 1; c <= 30; c++) begin
            left = (((c - 1) / 3) % 2) == 0;
            cyc();
            chk("bounce", c, outs, 6'b000000);
        end
        for (int c = 1; c <= 16; c++) begin
            left = (c <= 8);
            cyc();
            chk("bounce_hold", c, outs, {rng(c, 6, 13), 1'b0, 1'b0, (c == 6), 1'b0, 1'b0});
        end
        quiet("gap2");

        // Auto-repeat: right released so its debounced fall lands on the 7th strobe slot.
        for (int c = 1; c <= 46; c++) begin
            right = (c <= 35);
            cyc();
            chk("repeat", c, outs, {1'b0, rng(c, 6, 40), 1'b0, 1'b0,
                (c == 6 || c == 16 || c == 21 || c == 26 || c == 31 || c == 36), 1'b0});
        end
        quiet("gap3");

        // Both directions: pulses masked while both levels high, right keeps its phase.
        for (int c = 1; c <= 55; c++) begin
            left  = (c <= 25);
            right = (c >= 4) && (c <= 45);
            cyc();
            chk("both", c, outs, {rng(c, 6, 30), rng(c, 9, 50), 1'b0, (c == 6),
                (c == 34 || c == 39 || c == 44 || c == 49), 1'b0});
        end
        quiet("gap4");

        // Reset for two cycles while left is in REPEAT; fresh press detected afterwards.
        for (int c = 1; c <= 60; c++) begin
            left  = (c <= 48);
            reset = (c == 23) || (c == 24);
            cyc();
            chk("reset_hold", c, outs, {(rng(c, 6, 22) || rng(c, 30, 53)), 1'b0, 1'b0,
                (c == 6 || c == 16 || c == 21 || c == 30 || c == 40 || c == 45 || c == 50),
                1'b0, 1'b0});
        end
        reset = 1'b0;
        quiet("gap5");

        // Shoot and left pressed together: both strobes in cycle 6.
        for (int c = 1; c <= 20; c++) begin
            left  = (c <= 8);
            shoot = (c <= 8);
            cyc();
            chk("concurrent", c, outs, {rng(c, 6, 13), 1'b0, rng(c, 6, 13),
                (c == 6), 1'b0, (c == 6)});
        end
        quiet("gap6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
